// File: rtl/xillybus_mem_bank.sv
// Memory bank seen through a Xillybus seekable read/write stream pair, with an
// extra application port into the same RAM.
module xillybus_mem_bank #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int WRAP   = 1
) (
   input  logic              bus_clk,
   input  logic              bus_rst,
   input  logic [ADDR_W-1:0] user_mem_addr,
   input  logic              user_mem_addr_update,
   input  logic              user_r_mem_open,
   input  logic              user_r_mem_rden,
   output logic [DATA_W-1:0] user_r_mem_data,
   output logic              user_r_mem_empty,
   output logic              user_r_mem_eof,
   input  logic              user_w_mem_open,
   input  logic              user_w_mem_wren,
   input  logic [DATA_W-1:0] user_w_mem_data,
   output logic              user_w_mem_full,
   input  logic [ADDR_W-1:0] app_addr,
   input  logic              app_wren,
   input  logic [DATA_W-1:0] app_wdata,
   output logic [DATA_W-1:0] app_rdata
);

   localparam int unsigned     DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] PTR_END = {1'b1, {ADDR_W{1'b0}}};
   localparam logic            WRAP_EN = (WRAP != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_VALID,
      S_END
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_ptr;
   logic [ADDR_W:0]   w_ptr_nxt;
   logic [ADDR_W:0]   w_ptr_inc;
   logic [ADDR_W-1:0] w_ptr_lo;
   logic [ADDR_W-1:0] w_ptr_lo_inc;
   logic [ADDR_W-1:0] w_a_addr;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_app_rdata;
   logic              w_full;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_app_we;
   logic              w_unused;

   // The write stream's open flag carries no behaviour here.
   assign w_unused = user_w_mem_open;

   assign w_ptr_lo     = r_ptr[ADDR_W-1:0];
   assign w_ptr_lo_inc = w_ptr_lo + ADDR_W'(1);
   assign w_ptr_inc    = WRAP_EN ? {1'b0, w_ptr_lo_inc} : r_ptr + (ADDR_W+1)'(1);

   assign w_full   = !WRAP_EN && (r_ptr == PTR_END);
   assign w_wr_acc = user_w_mem_wren && !w_full && !user_mem_addr_update && !bus_rst;
   assign w_rd_acc = user_r_mem_rden && (r_state == S_VALID) && !user_mem_addr_update
                     && !w_wr_acc && !bus_rst;

   // Lookahead on an accepted read keeps the next word arriving in VALID.
   assign w_a_addr = w_rd_acc ? w_ptr_lo_inc : w_ptr_lo;
   assign w_app_we = app_wren && !(w_wr_acc && (app_addr == w_ptr_lo));

   always_ff @(posedge bus_clk) begin
      if (w_app_we) begin
         r_mem[app_addr] <= app_wdata;
      end
      if (w_wr_acc) begin
         r_mem[w_ptr_lo] <= user_w_mem_data;
      end
   end

   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         r_rdata     <= '0;
         r_app_rdata <= '0;
      end else begin
         r_rdata     <= r_mem[w_a_addr];
         r_app_rdata <= r_mem[app_addr];
      end
   end

   always_comb begin
      w_ptr_nxt = r_ptr;
      if (user_mem_addr_update) begin
         w_ptr_nxt = {1'b0, user_mem_addr};
      end else if (w_rd_acc || w_wr_acc) begin
         w_ptr_nxt = w_ptr_inc;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!user_r_mem_open) begin
         w_state_nxt = S_IDLE;
      end else if (user_mem_addr_update || w_wr_acc) begin
         w_state_nxt = S_FETCH;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = (!WRAP_EN && (r_ptr == PTR_END)) ? S_END : S_VALID;
            S_VALID: begin
               if (w_rd_acc && !WRAP_EN && (w_ptr_inc == PTR_END)) begin
                  w_state_nxt = S_END;
               end
            end
            S_END:   w_state_nxt = S_END;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         r_ptr   <= '0;
         r_state <= S_IDLE;
      end else begin
         r_ptr   <= w_ptr_nxt;
         r_state <= w_state_nxt;
      end
   end

   assign user_r_mem_data  = r_rdata;
   assign user_r_mem_empty = (r_state != S_VALID);
   assign user_r_mem_eof   = WRAP_EN ? 1'b0 : (r_state == S_END);
   assign user_w_mem_full  = w_full;
   assign app_rdata        = r_app_rdata;

endmodule

// File: tb/tb_xillybus_mem_bank.sv
// Directed bench: one wrapping and one non-wrapping instance share all inputs.
module tb_xillybus_mem_bank;

   logic       bus_clk;
   logic       bus_rst;
   logic [4:0] user_mem_addr;
   logic       user_mem_addr_update;
   logic       user_r_mem_open;
   logic       user_r_mem_rden;
   logic       user_w_mem_open;
   logic       user_w_mem_wren;
   logic [7:0] user_w_mem_data;
   logic [4:0] app_addr;
   logic       app_wren;
   logic [7:0] app_wdata;

   logic [7:0] data_w, data_n, ard_w, ard_n;
   logic       empty_w, empty_n, eof_w, eof_n, full_w, full_n;

   int n_pass  = 0;
   int n_total = 0;

   xillybus_mem_bank #(.DATA_W(8), .ADDR_W(5), .WRAP(1)) u_wrap (
      .bus_clk(bus_clk), .bus_rst(bus_rst),
      .user_mem_addr(user_mem_addr), .user_mem_addr_update(user_mem_addr_update),
      .user_r_mem_open(user_r_mem_open), .user_r_mem_rden(user_r_mem_rden),
      .user_r_mem_data(data_w), .user_r_mem_empty(empty_w), .user_r_mem_eof(eof_w),
      .user_w_mem_open(user_w_mem_open), .user_w_mem_wren(user_w_mem_wren),
      .user_w_mem_data(user_w_mem_data), .user_w_mem_full(full_w),
      .app_addr(app_addr), .app_wren(app_wren), .app_wdata(app_wdata), .app_rdata(ard_w)
   );

   xillybus_mem_bank #(.DATA_W(8), .ADDR_W(5), .WRAP(0)) u_nowrap (
      .bus_clk(bus_clk), .bus_rst(bus_rst),
      .user_mem_addr(user_mem_addr), .user_mem_addr_update(user_mem_addr_update),
      .user_r_mem_open(user_r_mem_open), .user_r_mem_rden(user_r_mem_rden),
      .user_r_mem_data(data_n), .user_r_mem_empty(empty_n), .user_r_mem_eof(eof_n),
      .user_w_mem_open(user_w_mem_open), .user_w_mem_wren(user_w_mem_wren),
      .user_w_mem_data(user_w_mem_data), .user_w_mem_full(full_n),
      .app_addr(app_addr), .app_wren(app_wren), .app_wdata(app_wdata), .app_rdata(ard_n)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   task automatic step();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic seek(input logic [4:0] a);
      user_mem_addr = a; user_mem_addr_update = 1'b1;
      step();
      user_mem_addr_update = 1'b0;
   endtask

   task automatic host_write(input logic [7:0] d);
      user_w_mem_wren = 1'b1; user_w_mem_data = d;
      step();
      user_w_mem_wren = 1'b0;
   endtask

   task automatic app_write(input logic [4:0] a, input logic [7:0] d);
      app_addr = a; app_wdata = d; app_wren = 1'b1;
      step();
      app_wren = 1'b0;
   endtask

   task automatic test_reset();
      bus_rst = 1'b1;
      step(); step();
      n_total++; if (empty_w !== 1'b1) $display("FAIL rst_empty_w: got %0b exp 1", empty_w); else n_pass++;
      n_total++; if (empty_n !== 1'b1) $display("FAIL rst_empty_n: got %0b exp 1", empty_n); else n_pass++;
      n_total++; if (eof_n !== 1'b0) $display("FAIL rst_eof_n: got %0b exp 0", eof_n); else n_pass++;
      n_total++; if (full_n !== 1'b0) $display("FAIL rst_full_n: got %0b exp 0", full_n); else n_pass++;
      n_total++; if (data_w !== 8'h00) $display("FAIL rst_data_w: got %h exp 00", data_w); else n_pass++;
      n_total++; if (ard_w !== 8'h00) $display("FAIL rst_ardata_w: got %h exp 00", ard_w); else n_pass++;
      bus_rst = 1'b0;
      step();
   endtask

   task automatic test_seq_read();
      seek(5'd3);
      host_write(8'hA1); host_write(8'hA2); host_write(8'hA3);
      seek(5'd3);
      user_r_mem_open = 1'b1;
      step();
      n_total++; if (empty_w !== 1'b1) $display("FAIL seq_fetch_empty: got %0b exp 1", empty_w); else n_pass++;
      step();
      n_total++; if (data_w !== 8'hA1) $display("FAIL seq_d0: got %h exp a1", data_w); else n_pass++;
      n_total++; if (empty_w !== 1'b0) $display("FAIL seq_e0: got %0b exp 0", empty_w); else n_pass++;
      user_r_mem_rden = 1'b1;
      step();
      n_total++; if (data_w !== 8'hA2) $display("FAIL seq_d1: got %h exp a2", data_w); else n_pass++;
      n_total++; if (empty_w !== 1'b0) $display("FAIL seq_e1: got %0b exp 0", empty_w); else n_pass++;
      step();
      n_total++; if (data_w !== 8'hA3) $display("FAIL seq_d2: got %h exp a3", data_w); else n_pass++;
      n_total++; if (data_n !== 8'hA3) $display("FAIL seq_d2_n: got %h exp a3", data_n); else n_pass++;
      n_total++; if (empty_w !== 1'b0) $display("FAIL seq_e2: got %0b exp 0", empty_w); else n_pass++;
      step();
      user_r_mem_rden = 1'b0;
      n_total++; if (empty_w !== 1'b0) $display("FAIL seq_e3: got %0b exp 0", empty_w); else n_pass++;
      user_r_mem_open = 1'b0;
      step();
   endtask

   task automatic test_wrap();
      seek(5'd31);
      host_write(8'h11);
      host_write(8'h22);
      n_total++; if (full_w !== 1'b0) $display("FAIL wrap_full_w: got %0b exp 0", full_w); else n_pass++;
      n_total++; if (full_n !== 1'b1) $display("FAIL wrap_full_n: got %0b exp 1", full_n); else n_pass++;
      app_addr = 5'd31;
      step();
      n_total++; if (ard_w !== 8'h11) $display("FAIL wrap_ram31: got %h exp 11", ard_w); else n_pass++;
      app_addr = 5'd0;
      step();
      n_total++; if (ard_w !== 8'h22) $display("FAIL wrap_ram0: got %h exp 22", ard_w); else n_pass++;
      seek(5'd31);
      user_r_mem_open = 1'b1;
      step(); step();
      n_total++; if (data_w !== 8'h11) $display("FAIL wrap_rd31_w: got %h exp 11", data_w); else n_pass++;
      n_total++; if (data_n !== 8'h11) $display("FAIL wrap_rd31_n: got %h exp 11", data_n); else n_pass++;
      user_r_mem_rden = 1'b1;
      step();
      user_r_mem_rden = 1'b0;
      n_total++; if (data_w !== 8'h22) $display("FAIL wrap_rd0_w: got %h exp 22", data_w); else n_pass++;
      n_total++; if (empty_w !== 1'b0) $display("FAIL wrap_empty_w: got %0b exp 0", empty_w); else n_pass++;
      n_total++; if (eof_n !== 1'b1) $display("FAIL wrap_eof_n: got %0b exp 1", eof_n); else n_pass++;
      user_r_mem_open = 1'b0;
      step();
   endtask

   task automatic test_end();
      app_write(5'd0, 8'h5A);
      seek(5'd30);
      host_write(8'h30);
      host_write(8'h31);
      n_total++; if (full_n !== 1'b1) $display("FAIL end_full0: got %0b exp 1", full_n); else n_pass++;
      host_write(8'hEE);
      n_total++; if (full_n !== 1'b1) $display("FAIL end_full1: got %0b exp 1", full_n); else n_pass++;
      app_addr = 5'd0;
      step();
      n_total++; if (ard_n !== 8'h5A) $display("FAIL end_ram0: got %h exp 5a", ard_n); else n_pass++;
      app_addr = 5'd31;
      step();
      n_total++; if (ard_n !== 8'h31) $display("FAIL end_ram31: got %h exp 31", ard_n); else n_pass++;
      seek(5'd30);
      user_r_mem_open = 1'b1;
      step(); step();
      n_total++; if (data_n !== 8'h30) $display("FAIL end_d30: got %h exp 30", data_n); else n_pass++;
      user_r_mem_rden = 1'b1;
      step();
      n_total++; if (data_n !== 8'h31) $display("FAIL end_d31: got %h exp 31", data_n); else n_pass++;
      n_total++; if (eof_n !== 1'b0) $display("FAIL end_eof_early: got %0b exp 0", eof_n); else n_pass++;
      step();
      user_r_mem_rden = 1'b0;
      n_total++; if (empty_n !== 1'b1) $display("FAIL end_empty: got %0b exp 1", empty_n); else n_pass++;
      n_total++; if (eof_n !== 1'b1) $display("FAIL end_eof: got %0b exp 1", eof_n); else n_pass++;
      n_total++; if (eof_w !== 1'b0) $display("FAIL end_eof_w: got %0b exp 0", eof_w); else n_pass++;
      seek(5'd0);
      n_total++; if (eof_n !== 1'b0) $display("FAIL end_seek_eof: got %0b exp 0", eof_n); else n_pass++;
      n_total++; if (empty_n !== 1'b1) $display("FAIL end_seek_fetch: got %0b exp 1", empty_n); else n_pass++;
      step();
      n_total++; if (empty_n !== 1'b0) $display("FAIL end_seek_valid: got %0b exp 0", empty_n); else n_pass++;
      n_total++; if (data_n !== 8'h5A) $display("FAIL end_seek_data: got %h exp 5a", data_n); else n_pass++;
      user_r_mem_open = 1'b0;
      step();
   endtask

   task automatic test_collision();
      seek(5'd7);
      app_write(5'd7, 8'h77);
      user_w_mem_wren = 1'b1; user_w_mem_data = 8'h55;
      app_wren = 1'b1; app_addr = 5'd7; app_wdata = 8'h66;
      step();
      user_w_mem_wren = 1'b0; app_wren = 1'b0;
      n_total++; if (ard_w !== 8'h77) $display("FAIL coll_old: got %h exp 77", ard_w); else n_pass++;
      step();
      n_total++; if (ard_w !== 8'h55) $display("FAIL coll_w: got %h exp 55", ard_w); else n_pass++;
      n_total++; if (ard_n !== 8'h55) $display("FAIL coll_n: got %h exp 55", ard_n); else n_pass++;
   endtask

   task automatic test_app_coherence();
      seek(5'd7);
      user_r_mem_open = 1'b1;
      step(); step();
      n_total++; if (data_w !== 8'h55) $display("FAIL coh_before: got %h exp 55", data_w); else n_pass++;
      app_write(5'd7, 8'h99);
      step(); step();
      n_total++; if (data_w !== 8'h99) $display("FAIL coh_after: got %h exp 99", data_w); else n_pass++;
      n_total++; if (empty_w !== 1'b0) $display("FAIL coh_empty: got %0b exp 0", empty_w); else n_pass++;
   endtask

   task automatic test_rw_same();
      app_write(5'd8, 8'h88);
      user_r_mem_rden = 1'b1; user_w_mem_wren = 1'b1; user_w_mem_data = 8'hC3;
      step();
      user_r_mem_rden = 1'b0; user_w_mem_wren = 1'b0;
      n_total++; if (empty_w !== 1'b1) $display("FAIL rw_fetch: got %0b exp 1", empty_w); else n_pass++;
      step();
      n_total++; if (data_w !== 8'h88) $display("FAIL rw_ptr: got %h exp 88", data_w); else n_pass++;
      app_addr = 5'd7;
      step();
      n_total++; if (ard_w !== 8'hC3) $display("FAIL rw_ram7: got %h exp c3", ard_w); else n_pass++;
   endtask

   task automatic test_seek_rden();
      app_write(5'd5, 8'h5F);
      app_write(5'd6, 8'h6F);
      user_r_mem_rden = 1'b1;
      seek(5'd5);
      user_r_mem_rden = 1'b0;
      n_total++; if (empty_w !== 1'b1) $display("FAIL sk_empty: got %0b exp 1", empty_w); else n_pass++;
      step();
      n_total++; if (empty_w !== 1'b0) $display("FAIL sk_valid: got %0b exp 0", empty_w); else n_pass++;
      n_total++; if (data_w !== 8'h5F) $display("FAIL sk_data: got %h exp 5f", data_w); else n_pass++;
   endtask

   task automatic test_reset_mid();
      app_write(5'd0, 8'hD0);
      app_write(5'd1, 8'hD1);
      user_r_mem_rden = 1'b1;
      step();
      n_total++; if (data_w !== 8'h6F) $display("FAIL rm_burst: got %h exp 6f", data_w); else n_pass++;
      bus_rst = 1'b1; user_w_mem_wren = 1'b1; user_w_mem_data = 8'hFF;
      step();
      n_total++; if (empty_w !== 1'b1) $display("FAIL rm_empty: got %0b exp 1", empty_w); else n_pass++;
      n_total++; if (eof_n !== 1'b0) $display("FAIL rm_eof: got %0b exp 0", eof_n); else n_pass++;
      n_total++; if (data_w !== 8'h00) $display("FAIL rm_data: got %h exp 00", data_w); else n_pass++;
      n_total++; if (ard_w !== 8'h00) $display("FAIL rm_ardata: got %h exp 00", ard_w); else n_pass++;
      bus_rst = 1'b0; user_w_mem_wren = 1'b0; user_r_mem_rden = 1'b0;
      step();
      n_total++; if (empty_w !== 1'b1) $display("FAIL rm_fetch: got %0b exp 1", empty_w); else n_pass++;
      step();
      n_total++; if (empty_w !== 1'b0) $display("FAIL rm_valid: got %0b exp 0", empty_w); else n_pass++;
      n_total++; if (data_w !== 8'hD0) $display("FAIL rm_ptr0: got %h exp d0", data_w); else n_pass++;
      user_r_mem_rden = 1'b1;
      step();
      user_r_mem_rden = 1'b0;
      n_total++; if (data_w !== 8'hD1) $display("FAIL rm_ptr1: got %h exp d1", data_w); else n_pass++;
      app_addr = 5'd0;
      step();
      n_total++; if (ard_w !== 8'hD0) $display("FAIL rm_ram0: got %h exp d0", ard_w); else n_pass++;
      app_addr = 5'd5;
      step();
      n_total++; if (ard_n !== 8'h5F) $display("FAIL rm_ram5: got %h exp 5f", ard_n); else n_pass++;
   endtask

   initial begin
      bus_rst = 1'b1;
      user_mem_addr = '0; user_mem_addr_update = 1'b0;
      user_r_mem_open = 1'b0; user_r_mem_rden = 1'b0;
      user_w_mem_open = 1'b1; user_w_mem_wren = 1'b0; user_w_mem_data = '0;
      app_addr = '0; app_wren = 1'b0; app_wdata = '0;
      test_reset();
      test_seq_read();
      test_wrap();
      test_end();
      test_collision();
      test_app_coherence();
      test_rw_same();
      test_seek_rden();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/xillybus_mem_bank.md
XILLYBUS_MEM_BANK -- requirements
Module: xillybus_mem_bank

Interface
REQ-001 Parameter DATA_W, default 8, sets word width of host data, application data and RAM.
REQ-002 Parameter ADDR_W, default 5, sets address width; RAM depth DEPTH = 2^ADDR_W words.
REQ-003 Parameter WRAP, default 1; 1 = pointer wraps modulo DEPTH, 0 = end-of-bank stops transfers.
REQ-004 Ports, in this order:
- bus_clk  in  1  sole clock; all logic is on its rising edge.
- bus_rst  in  1  synchronous, active-high reset.
- user_mem_addr  in  ADDR_W  seek address from core.
- user_mem_addr_update  in  1  load seek address strobe.
- user_r_mem_open  in  1  host read stream open.
- user_r_mem_rden  in  1  host read strobe.
- user_r_mem_data  out  DATA_W  read word.
- user_r_mem_empty  out  1  read word not available.
- user_r_mem_eof  out  1  end of bank reached.
- user_w_mem_open  in  1  host write stream open.
- user_w_mem_wren  in  1  host write strobe.
- user_w_mem_data  in  DATA_W  write word.
- user_w_mem_full  out  1  write not accepted.
- app_addr  in  ADDR_W  application port address.
- app_wren  in  1  application write enable.
- app_wdata  in  DATA_W  application write word.
- app_rdata  out  DATA_W  application read word.

Function
REQ-005 Storage: DEPTH x DATA_W two-port RAM; port A = host side, port B = application side; RAM contents are not initialised or cleared.
REQ-006 Shared pointer ptr, ADDR_W+1 bits; the MSB is used only when WRAP=0.
REQ-007 Seek: user_mem_addr_update=1 loads ptr <= {0, user_mem_addr} on that edge. It takes priority over rden/wren in the same cycle; those strobes are dropped.
REQ-008 Read-side state machine:
- IDLE: user_r_mem_open=0.
- FETCH: RAM output not yet valid for ptr.
- VALID: word for ptr presented.
- END: WRAP=0 and ptr==DEPTH.
REQ-009 Transitions:
- IDLE->FETCH on open rising.
- FETCH->VALID after exactly 1 cycle.
- Any state->FETCH on seek or accepted write.
- Any state->IDLE when open=0, this check having priority.
- VALID->END when ptr reaches DEPTH.
- END->FETCH on seek.
REQ-010 user_r_mem_empty=1 in IDLE, FETCH and END; 0 only in VALID.
REQ-011 Read strobe: user_r_mem_rden is honoured only when empty=0.
- It consumes the presented word and advances ptr by 1.
- The RAM read address is ptr+1 during that cycle (lookahead), so VALID holds and back-to-back rden sustains 1 word/cycle.
- rden while empty=1 is ignored.
REQ-012 user_r_mem_eof=1 only in END, asserted together with empty=1; it is constant 0 when WRAP=1.
REQ-013 Host write: user_w_mem_wren with full=0 writes user_w_mem_data to RAM[ptr], advances ptr by 1, and forces the read side to FETCH.
REQ-014 user_w_mem_full=1 when WRAP=0 and ptr==DEPTH, otherwise 0; wren while full=1 is ignored with no RAM change.
REQ-015 Wrap: when WRAP=1, ptr increments from DEPTH-1 to 0.
REQ-016 Application port:
- app_rdata is registered RAM[app_addr], 1-cycle latency, every cycle.
- app_wren writes app_wdata to RAM[app_addr].
- A read during a write to the same address returns the old data.
REQ-017 Collision: when a host write and app_wren target the same address in the same cycle, the host write wins and the app write is discarded.
REQ-018 After an app write to RAM[ptr], the read side presents the new word no later than 2 cycles after the write edge.
REQ-019 Host rden and wren asserted together in VALID: the write executes, the read is ignored, and the state goes to FETCH.

Reset
REQ-020 bus_rst=1 sets:
- ptr=0; state IDLE.
- user_r_mem_empty=1, user_r_mem_eof=0, user_w_mem_full=0.
- user_r_mem_data=0, app_rdata=0.
REQ-021 Reset mid-transfer aborts the transfer; strobes during reset are ignored; RAM contents are retained.
REQ-022 After reset release with open=1 held, the read side enters FETCH on the first edge and VALID one cycle later.

Verification
REQ-023 Defaults. Seek 3, write 0xA1,0xA2,0xA3, seek 3, open read, 3 rden back-to-back -> data 0xA1,0xA2,0xA3 on consecutive cycles; empty stays 0 throughout.
REQ-024 WRAP=1, ADDR_W=5. Seek 31, write 0x11,0x22 -> RAM[31]=0x11, RAM[0]=0x22; app_addr=0 gives app_rdata=0x22 one cycle later.
REQ-025 WRAP=0, ADDR_W=5. Seek 30, read 2 words -> next cycle empty=1, eof=1. wren then -> full=1 and RAM unchanged. Seek 0 -> eof=0, empty=0 after 1 cycle.
REQ-026 Same-cycle host wren 0x55 and app_wren 0x66 to address 7 -> RAM[7]=0x55.
REQ-027 addr_update=5 together with rden -> ptr=5, no extra advance, empty=1 one cycle then the word at 5.
REQ-028 bus_rst pulsed mid-read-burst -> next cycle empty=1, eof=0, ptr=0; RAM contents intact.
